dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target that answers load/store requests from the processor core's memory stage.
- Uses a valid/ready request channel and a valid/ready response channel.
- Latency is programmable, so the core and its stall logic can be exercised against a non-ideal memory.
- Sits between the core's data-memory port and the word-addressed storage array. The array is internal to this block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, extra cycles between request accept and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_read  input  1  load request.
- req_write  input  1  store request.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core takes response.
- rsp_rdata  output  32  load data.
- rsp_err  output  1  request was rejected.
- busy  output  1  transaction in progress (state != IDLE).

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Wait counter = 0.
  - Storage array is not cleared; its contents are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on a rising edge with req_valid=1.
  - At accept, latch req_read, req_write, req_addr and req_wdata into internal registers. Later changes on the req_* inputs are ignored.
  - If WAIT_CYCLES>0: go to WAIT and load the counter with WAIT_CYCLES-1.
  - If WAIT_CYCLES=0: go directly to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP on the next edge.
- Commit on the WAIT->RESP edge (or the IDLE->RESP edge when WAIT_CYCLES=0):
  - A store is written to the array on this edge.
  - A load samples the array on this edge.
  - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- Error checks (any one sets rsp_err=1):
  - Latched address is misaligned: addr[1:0]!=0.
  - Word index (addr-BASE_ADDR)>>2 >= DEPTH_WORDS. The subtraction is 32-bit unsigned; an address below BASE_ADDR wraps and is therefore out of range.
  - req_read and req_write both 1.
  - req_read and req_write both 0.
  - On error: rsp_err=1, rsp_rdata=0, no array write.
- Normal responses:
  - Store: rsp_rdata=0, rsp_err=0.
  - Load: rsp_rdata = array word, rsp_err=0.
- RESP:
  - req_ready=0.
  - rsp_valid=1. rsp_rdata and rsp_err are held stable.
  - Leave on the first edge with rsp_ready=1: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 in the following cycle. There is no back-to-back accept in the release cycle, so the minimum issue interval is WAIT_CYCLES+3 cycles when rsp_ready is held high.
- Ordering:
  - One outstanding transaction only.
  - A store's data is visible to any later load, since the commit happens before its response.
- Reset mid-operation:
  - From WAIT: the transaction is aborted, a pending store is never written, and no response is issued.
  - From RESP: an already-committed store stays in the array, and the response is dropped.
- rsp_ready=1 outside RESP has no effect.
- busy = 1 in WAIT and RESP, 0 in IDLE.

Test Plan:
- Reset and idle:
  - Check reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Assert rst mid-cycle with no clock edge -> same values appear immediately (asynchronous reset).
- Store then load, WAIT_CYCLES=2, rsp_ready held 1:
  - Store 0xDEADBEEF to addr 0x10, accept at edge 0 -> rsp_valid=1 after edge 3, rsp_rdata=0, rsp_err=0.
  - Next load of addr 0x10 -> rsp_rdata=0xDEADBEEF.
  - req_ready=0 from edge 1 through edge 3, back to 1 after edge 4.
- Backpressure:
  - Load of 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0xDEADBEEF held stable all 5 cycles.
  - Raise rsp_ready -> released on the next edge.
  - Change req_addr during WAIT -> response unaffected.
- Errors:
  - Store to 0x12 (misaligned) -> rsp_err=1.
  - Store to 0x400 with DEPTH_WORDS=256 (out of range) -> rsp_err=1.
  - Request with req_read=req_write=1 -> rsp_err=1.
  - After each, load of 0x10 still returns 0xDEADBEEF.
- WAIT_CYCLES=0, BASE_ADDR=0x1000:
  - Store 0x1234_5678 to 0x13FC -> rsp_valid=1 one cycle after accept.
  - Load of 0x13FC -> 0x1234_5678.
  - Load of 0x0FFC (below base, wraps) -> rsp_err=1.
- Reset during WAIT:
  - Store 0xA5A5A5A5 to 0x20 over existing 0x11111111, assert rst during WAIT -> no response.
  - Load of 0x20 after reset -> 0x11111111.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's memory stage.
// It accepts one load/store request at a time on a valid/ready request
// channel. It waits a programmable number of cycles, commits the access to
// an internal word array, and returns a response on a valid/ready channel.
//
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  - request handshake
//   req_read/req_write   - operation select (exactly one must be set)
//   req_addr, req_wdata  - byte address and store data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata, rsp_err   - load data (0 for stores and errors), error flag
//   busy                 - high while a transaction is outstanding
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic        acc_err;
    logic        commit;

    // Decode of the latched request. An address below BASE_ADDR wraps to a
    // huge offset and falls out of range on its own.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        word_idx = offset >> 2;
        mem_idx  = word_idx[IDX_W-1:0];
        acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS)) || (rd_q == wr_q);
        commit   = (state_q == StWait) && (cnt_q == 4'd0);
    end

    // The WAIT state lasts WAIT_CYCLES+1 cycles, and the commit happens on
    // its final edge. That puts rsp_valid exactly WAIT_CYCLES+1 edges after
    // accept, including when WAIT_CYCLES is 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rd_d    = req_read;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    err_d   = acc_err;
                    rdata_d = (!acc_err && rd_q) ? mem[mem_idx] : 32'h0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is never reset. A reset during WAIT aborts before commit,
    // so the pending store is dropped.
    always_ff @(posedge clk) begin
        if (commit && !acc_err && wr_q) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances are used:
//   index 0: WAIT_CYCLES=2, BASE_ADDR=0x0
//   index 1: WAIT_CYCLES=0, BASE_ADDR=0x1000
// Both have DEPTH_WORDS=256. The first part is a directed table of
// expectations. A hand-written reset-during-WAIT sequence follows, and the
// bench ends with random traffic checked against an array model of the memory.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_read  [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    dmem_responder #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_CYCLES(2)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst[0]),
        .req_valid(req_valid[0]),
        .req_ready(req_ready[0]),
        .req_read (req_read[0]),
        .req_write(req_write[0]),
        .req_addr (req_addr[0]),
        .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]),
        .rsp_err  (rsp_err[0]),
        .busy     (busy[0])
    );

    dmem_responder #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0000_1000),
        .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst[1]),
        .req_valid(req_valid[1]),
        .req_ready(req_ready[1]),
        .req_read (req_read[1]),
        .req_write(req_write[1]),
        .req_addr (req_addr[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]),
        .rsp_err  (rsp_err[1]),
        .busy     (busy[1])
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] base_of [2];
    int          wait_of [2];
    logic [31:0] model   [2][256];
    bit          known   [2][256];

    typedef struct {
        int          d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory behaviour: classify the access, apply stores, return load data.
    task automatic ref_model(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output bit err, output bit rd_known);
        logic [31:0] idx;
        idx      = (addr - base_of[d]) >> 2;
        err      = (addr[1:0] != 2'b00) || (idx >= 32'd256) || (rd == wr);
        rdata    = 32'h0;
        rd_known = 1'b1;
        if (!err && wr) begin
            model[d][idx[7:0]] = wdata;
            known[d][idx[7:0]] = 1'b1;
        end
        if (!err && rd) begin
            rdata    = model[d][idx[7:0]];
            rd_known = known[d][idx[7:0]];
        end
    endtask

    // Runs one transaction starting at a negedge and returns at a negedge.
    // hold = number of extra cycles rsp_ready is held low once rsp_valid appears.
    task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rdata, input bit exp_err, input bit chk_rdata);
        int n;
        bit bad_flags;
        check("req_ready_before_accept", {31'b0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1;
        req_read[d]  = rd;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        rsp_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        // Scramble the request inputs; the latched copy must be used.
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_read[d]  = 1'($urandom);
        req_write[d] = 1'($urandom);
        n = 0;
        bad_flags = 1'b0;
        @(negedge clk);
        while (!rsp_valid[d] && n < 40) begin
            if (req_ready[d] !== 1'b0 || busy[d] !== 1'b1) bad_flags = 1'b1;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("wait_flags_busy_not_ready", {31'b0, bad_flags}, 32'd0);
        check("rsp_latency", n, wait_of[d] + 1);
        check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, exp_err});
        if (chk_rdata) check("rsp_rdata", rsp_rdata[d], exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("held_rsp_valid", {31'b0, rsp_valid[d]}, 32'd1);
            if (chk_rdata) check("held_rsp_rdata", rsp_rdata[d], exp_rdata);
            check("held_rsp_err", {31'b0, rsp_err[d]}, {31'b0, exp_err});
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        check("released_valid_ready_busy",
              {29'b0, rsp_valid[d], req_ready[d], busy[d]}, 32'b010);
        check("released_rdata_err", rsp_rdata[d] | {31'b0, rsp_err[d]}, 32'h0);
        rsp_ready[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] e_rdata;
        bit          e_err;
        bit          e_known;

        base_of[0] = 32'h0000_0000;
        base_of[1] = 32'h0000_1000;
        wait_of[0] = 2;
        wait_of[1] = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_read[d]  = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b0;
        end

        vecs[0]  = '{0, 1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 0, 32'h0,        1'b0};
        vecs[1]  = '{0, 1'b1, 1'b0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 1'b0, 32'h10,   32'h0,        5, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h12,   32'h0BAD0BAD, 0, 32'h0,        1'b1};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h400,  32'h0BAD0BAD, 0, 32'h0,        1'b1};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{0, 1'b1, 1'b1, 32'h10,   32'h0BAD0BAD, 0, 32'h0,        1'b1};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{0, 1'b0, 1'b0, 32'h10,   32'h0BAD0BAD, 0, 32'h0,        1'b1};
        vecs[10] = '{0, 1'b0, 1'b1, 32'h3FC,  32'hCAFEF00D, 0, 32'h0,        1'b0};
        vecs[11] = '{0, 1'b1, 1'b0, 32'h3FC,  32'h0,        0, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{0, 1'b0, 1'b1, 32'h20,   32'h11111111, 0, 32'h0,        1'b0};
        vecs[13] = '{0, 1'b1, 1'b0, 32'h20,   32'h0,        0, 32'h11111111, 1'b0};
        vecs[14] = '{1, 1'b0, 1'b1, 32'h13FC, 32'h12345678, 0, 32'h0,        1'b0};
        vecs[15] = '{1, 1'b1, 1'b0, 32'h13FC, 32'h0,        2, 32'h12345678, 1'b0};
        vecs[16] = '{1, 1'b1, 1'b0, 32'h0FFC, 32'h0,        0, 32'h0,        1'b1};

        // Reset values.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_valid_ready_busy", {29'b0, rsp_valid[d], req_ready[d], busy[d]}, 32'b010);
            check("reset_rdata", rsp_rdata[d], 32'h0);
            check("reset_err", {31'b0, rsp_err[d]}, 32'h0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            ref_model(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      e_rdata, e_err, e_known);
            txn(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
        end

        // Reset during WAIT: the store must never land, and the reset acts
        // between clock edges.
        req_valid[0] = 1'b1;
        req_read[0]  = 1'b0;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hA5A5A5A5;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("in_wait_busy", {31'b0, busy[0]}, 32'd1);
        #2;
        rst[0] = 1'b1;
        #1;
        check("async_reset_valid_ready_busy",
              {29'b0, rsp_valid[0], req_ready[0], busy[0]}, 32'b010);
        check("async_reset_rdata_err", rsp_rdata[0] | {31'b0, rsp_err[0]}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("no_rsp_after_abort", {31'b0, rsp_valid[0]}, 32'd0);
        rst[0]       = 1'b0;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h11111111, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int          d;
            int          kind;
            int          op;
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            d     = int'($urandom_range(0, 1));
            kind  = int'($urandom_range(0, 9));
            op    = int'($urandom_range(0, 9));
            addr  = base_of[d] + ($urandom_range(0, 15) << 2);
            wdata = $urandom;
            if (kind == 0) addr = addr + $urandom_range(1, 3);
            if (kind == 1) addr = base_of[d] + 32'h400 + ($urandom_range(0, 15) << 2);
            if (kind == 2) addr = base_of[d] - 32'd4;
            rd = (op == 0) || (op >= 6);
            wr = (op == 0) || (op >= 2 && op < 6);
            ref_model(d, rd, wr, addr, wdata, e_rdata, e_err, e_known);
            txn(d, rd, wr, addr, wdata, int'($urandom_range(0, 2)), e_rdata, e_err, e_known);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
